// File: rtl/fetch_exec_unit.sv
// fetch_exec_unit
//   Accumulator datapath slaved to the run/halt sequencer's control-state bus.
//   A FETCH cycle latches one instruction from a combinational instruction
//   memory and advances the pc; the following EXEC cycle executes it.
//   An HLT instruction raises `halt` during its EXEC cycle so the sequencer
//   drops back to IDLE on the edge that ends EXEC.
//
// Ports
//   clk        in   system clock, state updates on posedge
//   reset      in   asynchronous, active-low reset
//   cs         in   [1:0] sequencer state (00 IDLE, 01 FETCH, 10 EXEC, 11 unused)
//   imem_addr  out  [PC_W-1:0] instruction address (the pc)
//   imem_data  in   [7:0] instruction at imem_addr, combinational read
//   halt       out  EXEC cycle of an HLT instruction
//   acc        out  [DATA_W-1:0] accumulator
//   zf, cf     out  zero and carry/borrow flags
//   out_data   out  [DATA_W-1:0] last value written by OUT
//   out_valid  out  one-cycle pulse per OUT
module fetch_exec_unit #(
    parameter int PC_W   = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        cs,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [7:0]        imem_data,
    output logic              halt,
    output logic [DATA_W-1:0] acc,
    output logic              zf,
    output logic              cf,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid
);

    typedef enum logic [1:0] {
        CS_IDLE  = 2'b00,
        CS_FETCH = 2'b01,
        CS_EXEC  = 2'b10,
        CS_RSVD  = 2'b11
    } cs_e;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LDI  = 3'b001;
    localparam logic [2:0] OP_ADDI = 3'b010;
    localparam logic [2:0] OP_SUBI = 3'b011;
    localparam logic [2:0] OP_JMP  = 3'b100;
    localparam logic [2:0] OP_JZ   = 3'b101;
    localparam logic [2:0] OP_OUT  = 3'b110;
    localparam logic [2:0] OP_HLT  = 3'b111;

    logic [PC_W-1:0]   r_pc;
    logic [7:0]        r_ir;
    logic [DATA_W-1:0] r_acc;
    logic              r_zf;
    logic              r_cf;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;

    logic [PC_W-1:0]   w_pc_nxt;
    logic [7:0]        w_ir_nxt;
    logic [DATA_W-1:0] w_acc_nxt;
    logic              w_zf_nxt;
    logic              w_cf_nxt;
    logic [DATA_W-1:0] w_out_data_nxt;
    logic              w_out_valid_nxt;

    logic [2:0]        w_op;
    logic [DATA_W-1:0] w_imm;
    logic [PC_W-1:0]   w_jmp_tgt;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_diff;

    assign w_op  = r_ir[7:5];
    assign w_imm = DATA_W'(r_ir[4:0]);
    // Size cast truncates or zero-extends the 5-bit immediate to the pc width.
    assign w_jmp_tgt = PC_W'(r_ir[4:0]);
    assign w_sum  = {1'b0, r_acc} + {1'b0, w_imm};
    assign w_diff = r_acc - w_imm;

    // Combinational so the sequencer sees it on the edge that ends EXEC.
    assign halt = (cs == CS_EXEC) && (w_op == OP_HLT);

    always_comb begin
        w_pc_nxt        = r_pc;
        w_ir_nxt        = r_ir;
        w_acc_nxt       = r_acc;
        w_zf_nxt        = r_zf;
        w_cf_nxt        = r_cf;
        w_out_data_nxt  = r_out_data;
        w_out_valid_nxt = 1'b0;
        case (cs)
            CS_FETCH: begin
                w_ir_nxt = imem_data;
                w_pc_nxt = r_pc + PC_W'(1);
            end
            CS_EXEC: begin
                case (w_op)
                    OP_NOP: ;
                    OP_LDI: begin
                        w_acc_nxt = w_imm;
                        w_zf_nxt  = (w_imm == '0);
                        w_cf_nxt  = 1'b0;
                    end
                    OP_ADDI: begin
                        w_acc_nxt = w_sum[DATA_W-1:0];
                        w_cf_nxt  = w_sum[DATA_W];
                        w_zf_nxt  = (w_sum[DATA_W-1:0] == '0);
                    end
                    OP_SUBI: begin
                        w_acc_nxt = w_diff;
                        w_cf_nxt  = (r_acc < w_imm);
                        w_zf_nxt  = (w_diff == '0);
                    end
                    OP_JMP: w_pc_nxt = w_jmp_tgt;
                    OP_JZ: begin
                        if (r_zf) w_pc_nxt = w_jmp_tgt;
                    end
                    OP_OUT: begin
                        w_out_data_nxt  = r_acc;
                        w_out_valid_nxt = 1'b1;
                    end
                    OP_HLT: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc        <= '0;
            r_ir        <= '0;
            r_acc       <= '0;
            r_zf        <= 1'b0;
            r_cf        <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_pc        <= w_pc_nxt;
            r_ir        <= w_ir_nxt;
            r_acc       <= w_acc_nxt;
            r_zf        <= w_zf_nxt;
            r_cf        <= w_cf_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    assign imem_addr = r_pc;
    assign acc       = r_acc;
    assign zf        = r_zf;
    assign cf        = r_cf;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_fetch_exec_unit.sv
// tb_fetch_exec_unit
//   Drives the control-state bus the way the sequencer would and models the
//   instruction memory as a small array. OUT results are pushed to a
//   scoreboard queue when the OUT is executed and popped when out_valid pulses.
module tb_fetch_exec_unit;

    localparam int PC_W   = 5;
    localparam int DATA_W = 8;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] FETCH = 2'b01;
    localparam logic [1:0] EXEC  = 2'b10;
    localparam logic [1:0] RSVD  = 2'b11;

    localparam logic [2:0] NOP  = 3'b000;
    localparam logic [2:0] LDI  = 3'b001;
    localparam logic [2:0] ADDI = 3'b010;
    localparam logic [2:0] SUBI = 3'b011;
    localparam logic [2:0] JMP  = 3'b100;
    localparam logic [2:0] JZ   = 3'b101;
    localparam logic [2:0] OUT  = 3'b110;
    localparam logic [2:0] HLT  = 3'b111;

    logic              clk;
    logic              reset;
    logic [1:0]        cs;
    logic [PC_W-1:0]   imem_addr;
    logic [7:0]        imem_data;
    logic              halt;
    logic [DATA_W-1:0] acc;
    logic              zf;
    logic              cf;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;

    logic [7:0]        mem [32];
    logic              x_mode;
    logic              exec_halt;

    logic [DATA_W-1:0] exp_q [$];
    int checks;
    int errors;

    fetch_exec_unit #(.PC_W(PC_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .cs        (cs),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .halt      (halt),
        .acc       (acc),
        .zf        (zf),
        .cf        (cf),
        .out_data  (out_data),
        .out_valid (out_valid)
    );

    assign imem_data = x_mode ? 8'hxx : mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ins(input logic [2:0] op, input logic [4:0] imm);
        return {op, imm};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) mem[i] = ins(NOP, 5'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        cs    = IDLE;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // One sequencer cycle; halt is sampled mid-cycle, outputs #1 after the edge.
    task automatic cycle(input logic [1:0] s);
        @(negedge clk);
        cs = s;
        #1 exec_halt = halt;
        @(posedge clk);
        #1;
    endtask

    // FETCH+EXEC pair; an OUT pushes the accumulator it will emit.
    task automatic run_instr(input logic [DATA_W-1:0] out_exp);
        cycle(FETCH);
        if (dut.r_ir[7:5] == OUT) exp_q.push_back(out_exp);
        cycle(EXEC);
    endtask

    task automatic check_state(input string name, input logic [DATA_W-1:0] e_acc,
                               input logic e_zf, input logic e_cf, input logic [PC_W-1:0] e_pc);
        checks++;
        if ({acc, zf, cf, imem_addr} !== {e_acc, e_zf, e_cf, e_pc}) begin
            errors++;
            $display("FAIL %s: acc=%h zf=%b cf=%b pc=%0d, expected acc=%h zf=%b cf=%b pc=%0d",
                     name, acc, zf, cf, imem_addr, e_acc, e_zf, e_cf, e_pc);
        end
    endtask

    task automatic check_out_pulse(input string name);
        logic [DATA_W-1:0] e;
        checks++;
        if (out_valid !== 1'b1 || exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: out_valid=%b queued=%0d, expected pulse with one queued value",
                     name, out_valid, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if (out_data !== e) begin
                errors++;
                $display("FAIL %s: out_data=%h expected %h", name, out_data, e);
            end
        end
    endtask

    task automatic test_reset();
        x_mode = 1'b1;
        cs     = 2'bxx;
        reset  = 1'b0;
        #23;
        checks++;
        if ({imem_addr, acc, zf, cf, out_data, out_valid, halt} !== '0) begin
            errors++;
            $display("FAIL reset_state: pc=%0d acc=%h zf=%b cf=%b out=%h ov=%b halt=%b, expected all 0",
                     imem_addr, acc, zf, cf, out_data, out_valid, halt);
        end
        x_mode = 1'b0;
        cs     = IDLE;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_program();
        clear_mem();
        mem[0] = ins(LDI, 5'd5);
        mem[1] = ins(ADDI, 5'd3);
        mem[2] = ins(OUT, 5'd0);
        mem[3] = ins(HLT, 5'd0);
        do_reset();
        run_instr('0);
        check_state("prog_ldi", 8'd5, 1'b0, 1'b0, 5'd1);
        checks++;
        if (exec_halt !== 1'b0) begin
            errors++;
            $display("FAIL prog_halt_ldi: halt=%b expected 0", exec_halt);
        end
        run_instr('0);
        check_state("prog_addi", 8'd8, 1'b0, 1'b0, 5'd2);
        run_instr(8'd8);
        check_out_pulse("prog_out");
        cycle(FETCH);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL prog_out_one_cycle: out_valid=%b expected 0", out_valid);
        end
        cycle(EXEC);
        checks++;
        if (exec_halt !== 1'b1) begin
            errors++;
            $display("FAIL prog_halt: halt=%b expected 1", exec_halt);
        end
        check_state("prog_after_hlt", 8'd8, 1'b0, 1'b0, 5'd4);
        cycle(IDLE);
        checks++;
        if (exec_halt !== 1'b0) begin
            errors++;
            $display("FAIL prog_halt_idle: halt=%b expected 0", exec_halt);
        end
    endtask

    task automatic test_flags();
        clear_mem();
        mem[0] = ins(LDI, 5'd1);
        mem[1] = ins(SUBI, 5'd2);
        mem[2] = ins(ADDI, 5'd1);
        do_reset();
        run_instr('0);
        run_instr('0);
        check_state("flags_subi_borrow", 8'hFF, 1'b0, 1'b1, 5'd2);
        run_instr('0);
        check_state("flags_addi_carry", 8'h00, 1'b1, 1'b1, 5'd3);
    endtask

    task automatic test_jumps();
        clear_mem();
        mem[0] = ins(LDI, 5'd0);
        mem[1] = ins(JZ, 5'd7);
        mem[7] = ins(LDI, 5'd1);
        mem[8] = ins(JZ, 5'd7);
        mem[9] = ins(JMP, 5'd31);
        do_reset();
        run_instr('0);
        run_instr('0);
        check_state("jz_taken", 8'd0, 1'b1, 1'b0, 5'd7);
        run_instr('0);
        run_instr('0);
        check_state("jz_not_taken", 8'd1, 1'b0, 1'b0, 5'd9);
        run_instr('0);
        check_state("jmp_31", 8'd1, 1'b0, 1'b0, 5'd31);
        cycle(FETCH);
        check_state("pc_wrap", 8'd1, 1'b0, 1'b0, 5'd0);
        cycle(EXEC);
    endtask

    task automatic test_idle_hold();
        clear_mem();
        mem[0] = ins(LDI, 5'd6);
        mem[1] = ins(OUT, 5'd0);
        do_reset();
        run_instr('0);
        cycle(FETCH);
        for (int k = 0; k < 20; k++) begin
            cycle(k < 10 ? IDLE : RSVD);
            checks++;
            if ({acc, imem_addr, zf, cf, out_data, out_valid, exec_halt}
                !== {8'd6, 5'd2, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL idle_hold[%0d]: acc=%h pc=%0d zf=%b cf=%b out=%h ov=%b halt=%b",
                         k, acc, imem_addr, zf, cf, out_data, out_valid, exec_halt);
            end
        end
        exp_q.push_back(8'd6);
        cycle(EXEC);
        check_out_pulse("idle_resume_out");
    endtask

    task automatic test_reset_mid_exec();
        clear_mem();
        mem[0] = ins(LDI, 5'd9);
        mem[1] = ins(OUT, 5'd0);
        do_reset();
        run_instr('0);
        check_state("rst_pre", 8'd9, 1'b0, 1'b0, 5'd1);
        cycle(FETCH);
        @(negedge clk);
        cs = EXEC;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({acc, imem_addr, out_valid} !== '0) begin
            errors++;
            $display("FAIL rst_async: acc=%h pc=%0d ov=%b expected 0", acc, imem_addr, out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL rst_exec_edge: ov=%b out=%h expected 0", out_valid, out_data);
        end
        @(negedge clk);
        cs    = IDLE;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_state("rst_release", 8'd0, 1'b0, 1'b0, 5'd0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_release_ov: ov=%b expected 0", out_valid);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exec_halt = 1'b0;
        clear_mem();
        test_reset();
        test_program();
        test_flags();
        test_jumps();
        test_idle_hold();
        test_reset_mid_exec();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expected outputs never seen", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/fetch_exec_unit.md
# fetch_exec_unit

Accumulator datapath driven by the 2-bit control-state bus `cs` (IDLE 2'b00, FETCH 2'b01, EXEC 2'b10) of the run/halt sequencer. It fetches one 8-bit instruction per FETCH cycle from an external combinational instruction memory and executes it in the following EXEC cycle. It returns `halt` to the sequencer so that an HLT instruction drops the machine back to IDLE. Sits directly downstream of the sequencer and upstream of the output port logic.

## Interface
- `PC_W`, default 5: program counter width; instruction memory depth is 2^PC_W.
- `DATA_W`, default 8: accumulator/output width; must be ≥ 5.
- `clk`  input  1  system clock, all state updates on posedge.
- `reset`  input  1  asynchronous, active-low reset. One clock; reset asynchronous and active-low.
- `cs`  input  2  sequencer state: 00 IDLE, 01 FETCH, 10 EXEC, 11 unused.
- `imem_addr`  output  PC_W  instruction address, equals `pc`.
- `imem_data`  input  8  instruction at `imem_addr`, combinational read.
- `halt`  output  1  combinational: 1 iff `cs`==EXEC and `ir[7:5]`==3'b111.
- `acc`  output  DATA_W  accumulator.
- `zf`, `cf`  output  1 each  zero and carry/borrow flags.
- `out_data`  output  DATA_W  last value written by OUT.
- `out_valid`  output  1  one-cycle pulse per OUT.

## Operation
- Instruction format: `op`=ir[7:5], `imm`=ir[4:0], zero-extended to DATA_W.
- cs==FETCH at posedge: `ir`<=`imem_data`; `pc`<=`pc`+1 mod 2^PC_W.
- cs==EXEC at posedge: execute `ir`:
  - 000 NOP: no change.
  - 001 LDI: acc<=imm; zf<=(imm==0); cf<=0.
  - 010 ADDI: {cf,acc}<=acc+imm (DATA_W+1 bits); zf<=(result==0).
  - 011 SUBI: acc<=acc−imm mod 2^DATA_W; cf<=(acc<imm) borrow; zf<=(result==0).
  - 100 JMP: pc<=imm[PC_W-1:0] (upper imm bits ignored if PC_W<5; zero-extended if PC_W>5).
  - 101 JZ: if zf, pc<=imm; else no change.
  - 110 OUT: out_data<=acc; out_valid<=1.
  - 111 HLT: no register change; `halt` asserted this cycle.
- cs==IDLE or 2'b11: all registers hold; `halt`=0.
- `out_valid` cleared on every posedge where it was not set by OUT.
- Flags change only on LDI/ADDI/SUBI.
- After HLT, `pc` points to the instruction after HLT; a new `run` resumes from there.

## Timing
- Reset (async, asserted low): pc=0, ir=0, acc=0, zf=0, cf=0, out_data=0, out_valid=0; `halt`=0 since ir=NOP.
- One instruction per FETCH+EXEC pair = 2 cycles.
- `imem_addr` changes the cycle after a FETCH edge or taken jump; `imem_data` must be valid before the next FETCH edge.
- Register results (acc, flags, pc on jump) are visible the cycle after the EXEC edge; `out_valid` high exactly that one cycle.
- `halt` is valid during the EXEC cycle, combinational from `cs` and `ir`, so the sequencer samples it on the same edge that ends EXEC.
- PC wrap: pc=2^PC_W−1 fetch → pc=0.
- Reset mid-EXEC: all registers clear immediately; instruction not committed; out_valid forced 0.

## Test plan
- Reset with X on all inputs → all outputs at reset values, `halt`=0, `imem_addr`=0.
- Program LDI 5; ADDI 3; OUT; HLT at 0..3, cycle cs FETCH/EXEC → out_data=8, out_valid one cycle after OUT's EXEC, `halt`=1 in 4th EXEC, pc=4.
- LDI 1; SUBI 2 → acc=8'hFF, cf=1, zf=0; then ADDI 1 → acc=0, cf=1, zf=1.
- LDI 0; JZ 7 → pc=7; LDI 1; JZ 7 → pc advances, no jump; JMP 31 then FETCH → pc wraps to 0.
- Hold cs=IDLE and cs=2'b11 for 10 cycles mid-program → no register changes, `halt`=0, out_valid=0.
- Assert `reset` low during EXEC of OUT → out_valid stays 0, acc=0, pc=0 on release.
